// File: rtl/letter_pool.sv
// letter_pool: active-letter store for the falling-letter typing game.
// Captures generated letters into free slots, moves live letters down the
// screen on each frame tick, matches typed keys against live letters and
// keeps saturating hit / fallen-letter totals for the scoreboard.
module letter_pool #(
  parameter int         SLOTS    = 8,
  parameter logic [8:0] X_BOTTOM = 9'd460
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               gen_ch,
  input  logic [2:0]               gen_speed,
  input  logic [8:0]               gen_x,
  input  logic [9:0]               gen_y,
  input  logic                     spawn_tick,
  input  logic                     frame_tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_ch,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [7:0]               rd_ch,
  output logic [8:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic [SLOTS-1:0]         active_mask,
  output logic                     full,
  output logic                     hit,
  output logic                     wrong,
  output logic                     miss,
  output logic                     spawn_drop,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int IW = $clog2(SLOTS);

  // Slot storage
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [7:0]       ch_q    [SLOTS];
  logic [7:0]       ch_d    [SLOTS];
  logic [2:0]       speed_q [SLOTS];
  logic [2:0]       speed_d [SLOTS];
  logic [8:0]       x_q     [SLOTS];
  logic [8:0]       x_d     [SLOTS];
  logic [9:0]       y_q     [SLOTS];
  logic [9:0]       y_d     [SLOTS];

  // Counters, event pulses and readout registers
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        hit_q, hit_d;
  logic        wrong_q, wrong_d;
  logic        miss_q, miss_d;
  logic        spawn_drop_q, spawn_drop_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_ch_q, rd_ch_d;
  logic [8:0]  rd_x_q, rd_x_d;
  logic [9:0]  rd_y_q, rd_y_d;

  // Intermediate decisions
  logic [7:0]    key_fold;
  logic          key_found;
  logic [IW-1:0] key_win;
  logic [8:0]    key_best_x;
  logic          key_hit;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          gen_ok;
  logic          spawn_ok;
  logic [9:0]    frame_sum [SLOTS];
  logic [4:0]    fall_cnt;
  logic [16:0]   miss_sum;

  // Fold the key to uppercase and pick the lowest live letter (largest x, lowest index on tie)
  always_comb begin
    key_fold   = key_ch;
    key_found  = 1'b0;
    key_win    = '0;
    key_best_x = '0;
    if (key_ch >= 8'h61 && key_ch <= 8'h7A) begin
      key_fold = key_ch - 8'h20;
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (valid_q[i] && (ch_q[i] == key_fold) && (!key_found || (x_q[i] > key_best_x))) begin
        key_found  = 1'b1;
        key_win    = IW'(i);
        key_best_x = x_q[i];
      end
    end
  end

  // Lowest-index slot that was free at the start of the cycle
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Candidate new row for every slot; a 10-bit sum so overshoot past row 511 is still caught
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      frame_sum[i] = {1'b0, x_q[i]} + {7'b0, speed_q[i]};
    end
  end

  // Slot next-state: key first, then frame advance, then spawn
  always_comb begin
    valid_d  = valid_q;
    ch_d     = ch_q;
    speed_d  = speed_q;
    x_d      = x_q;
    y_d      = y_q;
    fall_cnt = '0;
    key_hit  = key_valid && key_found;
    gen_ok   = (gen_ch >= 8'h41) && (gen_ch <= 8'h5A) && (gen_speed != 3'd0);
    spawn_ok = spawn_tick && gen_ok && free_found;

    if (key_hit) begin
      valid_d[key_win] = 1'b0;
    end

    if (frame_tick) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (valid_q[i] && !(key_hit && (key_win == IW'(i)))) begin
          if (frame_sum[i] >= {1'b0, X_BOTTOM}) begin
            valid_d[i] = 1'b0;
            fall_cnt   = fall_cnt + 5'd1;
          end else begin
            x_d[i] = frame_sum[i][8:0];
          end
        end
      end
    end

    // The chosen slot was not live at the start of the cycle, so neither key nor frame touched it
    if (spawn_ok) begin
      valid_d[free_idx] = 1'b1;
      ch_d[free_idx]    = gen_ch;
      speed_d[free_idx] = gen_speed;
      x_d[free_idx]     = gen_x;
      y_d[free_idx]     = gen_y;
    end
  end

  // Saturating totals and one-cycle event pulses
  always_comb begin
    hit_count_d = hit_count_q;
    if (key_hit && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    miss_sum     = {1'b0, miss_count_q} + 17'(fall_cnt);
    miss_count_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    hit_d        = key_hit;
    wrong_d      = key_valid && !key_found;
    miss_d       = (fall_cnt != 5'd0);
    spawn_drop_d = spawn_tick && !spawn_ok;
  end

  // Renderer readout samples the selected slot as it stands before this edge
  always_comb begin
    rd_valid_d = valid_q[rd_idx];
    rd_ch_d    = ch_q[rd_idx];
    rd_x_d     = x_q[rd_idx];
    rd_y_d     = y_q[rd_idx];
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ch_q[i]    <= '0;
        speed_q[i] <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      speed_q <= speed_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Counter, pulse and readout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      hit_q        <= 1'b0;
      wrong_q      <= 1'b0;
      miss_q       <= 1'b0;
      spawn_drop_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_ch_q      <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      hit_q        <= hit_d;
      wrong_q      <= wrong_d;
      miss_q       <= miss_d;
      spawn_drop_q <= spawn_drop_d;
      rd_valid_q   <= rd_valid_d;
      rd_ch_q      <= rd_ch_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
    end
  end

  assign active_mask = valid_q;
  assign full        = &valid_q;
  assign hit         = hit_q;
  assign wrong       = wrong_q;
  assign miss        = miss_q;
  assign spawn_drop  = spawn_drop_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign rd_valid    = rd_valid_q;
  assign rd_ch       = rd_ch_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;

endmodule

// File: tb/tb_letter_pool.sv
// Scoreboard bench for letter_pool: a driver applies directed and random
// stimulus, updates a behavioural model and queues the expected post-edge
// outputs; a monitor pops and compares them on the falling edge.
module tb_letter_pool;

  localparam int SLOTS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gen_ch = '0;
  logic [2:0]  gen_speed = '0;
  logic [8:0]  gen_x = '0;
  logic [9:0]  gen_y = '0;
  logic        spawn_tick = 1'b0;
  logic        frame_tick = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ch = '0;
  logic [2:0]  rd_idx = '0;
  logic        rd_valid;
  logic [7:0]  rd_ch;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic [7:0]  active_mask;
  logic        full, hit, wrong, miss, spawn_drop;
  logic [15:0] hit_count, miss_count;

  letter_pool #(.SLOTS(SLOTS), .X_BOTTOM(9'd460)) dut (
    .clk(clk), .rst_n(rst_n),
    .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
    .spawn_tick(spawn_tick), .frame_tick(frame_tick),
    .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .active_mask(active_mask), .full(full), .hit(hit), .wrong(wrong),
    .miss(miss), .spawn_drop(spawn_drop),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic        hit, wrong, miss, drop, full, rv;
    logic [7:0]  mask, rch;
    logic [15:0] hc, mc;
    logic [8:0]  rx;
    logic [9:0]  ry;
  } exp_t;
  exp_t sb[$];

  // Reference model: slot contents as plain integers
  bit         m_v  [SLOTS];
  int         m_ch [SLOTS];
  int         m_sp [SLOTS];
  int         m_x  [SLOTS];
  int         m_y  [SLOTS];
  int         m_hits = 0;
  int         m_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      m_v[i] = 0; m_ch[i] = 0; m_sp[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  // Apply the current tb inputs to the model for the coming edge and queue the outcome
  task automatic model_step();
    exp_t e;
    int   k, win, falls, free_i, ri;
    ri      = int'(rd_idx);
    e.cyc   = cyc + 1;
    e.rv    = m_v[ri];
    e.rch   = 8'(m_ch[ri]);
    e.rx    = 9'(m_x[ri]);
    e.ry    = 10'(m_y[ri]);
    e.hit   = 0;
    e.wrong = 0;
    e.drop  = 0;
    free_i  = -1;
    for (int i = 0; i < SLOTS; i++) if (!m_v[i] && free_i < 0) free_i = i;
    if (key_valid) begin
      k = int'(key_ch);
      if (k >= 'h61 && k <= 'h7A) k = k - 'h20;
      win = -1;
      for (int i = 0; i < SLOTS; i++)
        if (m_v[i] && m_ch[i] == k && (win < 0 || m_x[i] > m_x[win])) win = i;
      if (win >= 0) begin
        m_v[win] = 0;
        e.hit = 1;
        if (m_hits < 65535) m_hits++;
      end else begin
        e.wrong = 1;
      end
    end
    falls = 0;
    if (frame_tick) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (m_v[i]) begin
          if (m_x[i] + m_sp[i] >= 460) begin
            m_v[i] = 0;
            falls++;
          end else begin
            m_x[i] = m_x[i] + m_sp[i];
          end
        end
      end
    end
    m_miss = (m_miss + falls > 65535) ? 65535 : m_miss + falls;
    e.miss = (falls > 0);
    if (spawn_tick) begin
      if (gen_ch < 8'h41 || gen_ch > 8'h5A || gen_speed == 0 || free_i < 0) begin
        e.drop = 1;
      end else begin
        m_v[free_i]  = 1;
        m_ch[free_i] = int'(gen_ch);
        m_sp[free_i] = int'(gen_speed);
        m_x[free_i]  = int'(gen_x);
        m_y[free_i]  = int'(gen_y);
      end
    end
    e.full = 1;
    for (int i = 0; i < SLOTS; i++) begin
      e.mask[i] = m_v[i];
      if (!m_v[i]) e.full = 0;
    end
    e.hc = 16'(m_hits);
    e.mc = 16'(m_miss);
    sb.push_back(e);
  endtask

  // One cycle of stimulus; called just after a rising edge and returns just after the next
  task automatic drive(input bit sp, input logic [7:0] gc, input logic [2:0] gs,
                       input logic [8:0] gx, input logic [9:0] gy, input bit fr,
                       input bit kv, input logic [7:0] kc, input logic [2:0] ri);
    spawn_tick = sp; gen_ch = gc; gen_speed = gs; gen_x = gx; gen_y = gy;
    frame_tick = fr; key_valid = kv; key_ch = kc; rd_idx = ri;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] ri);
    drive(0, 8'h00, 3'd0, 9'd0, 10'd0, 0, 0, 8'h00, ri);
  endtask

  task automatic check_all_zero();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_ch", 32'(rd_ch), 0);
    chk("rst_rd_x", 32'(rd_x), 0);
    chk("rst_rd_y", 32'(rd_y), 0);
    chk("rst_mask", 32'(active_mask), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_pulses", 32'({hit, wrong, miss, spawn_drop}), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
  endtask

  // Drain the scoreboard, then pull reset low mid-frame and check outputs clear before any edge
  task automatic do_reset();
    int n = 0;
    while (sb.size() != 0 && n < 6) begin
      @(negedge clk);
      #1;
      n++;
    end
    frame_tick = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_all_zero();
    frame_tick = 1'b0;
    spawn_tick = 1'b0;
    key_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Monitor: compare each queued expectation on the falling edge after its rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        errors++;
        $display("FAIL stale_entry: expectation for cycle %0d never compared (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("hit", 32'(hit), 32'(e.hit));
        chk("wrong", 32'(wrong), 32'(e.wrong));
        chk("miss", 32'(miss), 32'(e.miss));
        chk("spawn_drop", 32'(spawn_drop), 32'(e.drop));
        chk("active_mask", 32'(active_mask), 32'(e.mask));
        chk("full", 32'(full), 32'(e.full));
        chk("hit_count", 32'(hit_count), 32'(e.hc));
        chk("miss_count", 32'(miss_count), 32'(e.mc));
        chk("rd_valid", 32'(rd_valid), 32'(e.rv));
        chk("rd_ch", 32'(rd_ch), 32'(e.rch));
        chk("rd_x", 32'(rd_x), 32'(e.rx));
        chk("rd_y", 32'(rd_y), 32'(e.ry));
      end
    end
  end

  initial begin : stimulus
    int n;
    int live [$];
    logic [7:0] c;
    model_clear();
    #2;
    check_all_zero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Spawn into an empty pool, then read it back
    drive(1, 8'h41, 3'd2, 9'd0, 10'd90, 0, 0, 8'h00, 3'd0);
    idle(3'd0);
    idle(3'd0);

    // Key priority: deepest letter wins, lowercase folds; then an unmatched key
    do_reset();
    drive(1, 8'h42, 3'd1, 9'd0, 10'd10, 0, 0, 8'h00, 3'd0);
    drive(1, 8'h42, 3'd1, 9'd50, 10'd20, 0, 0, 8'h00, 3'd1);
    drive(0, 8'h00, 3'd0, 9'd0, 10'd0, 0, 1, 8'h62, 3'd1);
    drive(0, 8'h00, 3'd0, 9'd0, 10'd0, 0, 1, 8'h5A, 3'd1);
    idle(3'd0);
    idle(3'd1);

    // Falling: one letter crosses the bottom, the other advances
    do_reset();
    drive(1, 8'h43, 3'd3, 9'd458, 10'd5, 0, 0, 8'h00, 3'd0);
    drive(1, 8'h44, 3'd1, 9'd400, 10'd6, 0, 0, 8'h00, 3'd0);
    drive(0, 8'h00, 3'd0, 9'd0, 10'd0, 1, 0, 8'h00, 3'd1);
    idle(3'd1);
    idle(3'd1);

    // Full pool with key, frame and spawn together; freed slot is reused next cycle
    do_reset();
    for (int i = 0; i < SLOTS; i++)
      drive(1, 8'(8'h41 + i), 3'd1, 9'd0, 10'(i), 0, 0, 8'h00, 3'd0);
    drive(1, 8'h58, 3'd2, 9'd7, 10'd77, 1, 1, 8'h63, 3'd2);
    drive(1, 8'h59, 3'd2, 9'd9, 10'd99, 0, 0, 8'h00, 3'd2);
    idle(3'd2);
    idle(3'd2);

    // Invalid spawns leave the pool unchanged
    do_reset();
    drive(1, 8'h30, 3'd2, 9'd0, 10'd0, 0, 0, 8'h00, 3'd0);
    drive(1, 8'h45, 3'd0, 9'd0, 10'd0, 0, 0, 8'h00, 3'd0);
    drive(1, 8'h5B, 3'd1, 9'd0, 10'd0, 0, 0, 8'h00, 3'd0);
    idle(3'd0);

    // Random traffic with a reset in the middle
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) do_reset();
      live.delete();
      for (int i = 0; i < SLOTS; i++) if (m_v[i]) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 9) < 6) begin
        c = 8'(m_ch[live[$urandom_range(0, live.size() - 1)]]);
        if ($urandom_range(0, 1) == 1) c = c + 8'h20;
      end else begin
        c = 8'($urandom);
      end
      drive($urandom_range(0, 9) < 4,
            ($urandom_range(0, 9) < 9) ? 8'(8'h41 + $urandom_range(0, 5)) : 8'($urandom),
            3'($urandom),
            ($urandom_range(0, 1) == 1) ? 9'(50 * $urandom_range(0, 9)) : 9'($urandom_range(0, 470)),
            10'($urandom),
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 4,
            c,
            3'($urandom));
    end

    // Hit counter saturation: one hit per cycle past 0xFFFF
    do_reset();
    for (int t = 0; t < 65540; t++)
      drive(1, 8'h41, 3'd1, 9'd0, 10'd0, 0, 1, 8'h41, 3'd0);
    idle(3'd0);
    idle(3'd0);

    // Reset mid-frame after saturation clears everything
    do_reset();
    idle(3'd0);

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
